// File: rtl/branch_predictor.sv
// Next-PC generator: bimodal counter table for branches, JAL redirect, JALR stall-until-resolve.
module branch_predictor #(
    parameter int unsigned BHT_IDX_W = 6,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned CTR_INIT  = 2 ** (CTR_W - 1)
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _br_rob,
    input  logic [31:0] _rob_new_pc,
    input  logic [31:0] _rob_imm,
    input  logic        _clear,
    input  logic [31:0] _inst_in,
    input  logic        _inst_ready_in,
    input  logic [31:0] _inst_addr,
    input  logic        _upd_valid,
    input  logic [31:0] _upd_pc,
    input  logic        _upd_taken,
    output logic        _stall,
    output logic [31:0] _next_pc,
    output logic        _pred_taken
);

    localparam int unsigned     BHT_DEPTH  = 1 << BHT_IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX    = '1;
    localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);
    localparam logic [6:0]       OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]       OP_JAL     = 7'b1101111;
    localparam logic [6:0]       OP_JALR    = 7'b1100111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [CTR_W-1:0]     ctr_q [BHT_DEPTH];
    logic [CTR_W-1:0]     ctr_cur;
    logic [CTR_W-1:0]     ctr_d;
    logic [BHT_IDX_W-1:0] look_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [6:0]           opcode;
    logic [31:0]          br_imm;
    logic [31:0]          jal_imm;
    logic                 is_br;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 pred_msb;
    logic                 unused_upd_pc;

    // Instruction decode and table indexing
    assign opcode   = _inst_in[6:0];
    assign is_br    = (opcode == OP_BRANCH);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign br_imm   = {{19{_inst_in[31]}}, _inst_in[31], _inst_in[7],
                       _inst_in[30:25], _inst_in[11:8], 1'b0};
    assign jal_imm  = {{11{_inst_in[31]}}, _inst_in[31], _inst_in[19:12],
                       _inst_in[20], _inst_in[30:21], 1'b0};
    assign look_idx = _inst_addr[BHT_IDX_W+1:2];
    assign upd_idx  = _upd_pc[BHT_IDX_W+1:2];
    assign pred_msb = ctr_q[look_idx][CTR_W-1];
    assign ctr_cur  = ctr_q[upd_idx];

    assign unused_upd_pc = ^{_upd_pc[31:BHT_IDX_W+2], _upd_pc[1:0]};

    // FSM next state and combinational fetch outputs
    always_comb begin
        state_d     = state_q;
        _next_pc    = _inst_addr + 32'd4;
        _pred_taken = 1'b0;
        _stall      = 1'b0;

        if (_inst_ready_in && is_br) begin
            _pred_taken = pred_msb;
        end

        if (_br_rob) begin
            _next_pc = _rob_new_pc + _rob_imm;
        end else if (state_q == S_WAIT) begin
            _next_pc = _inst_addr;
        end else if (!_inst_ready_in) begin
            _next_pc = _inst_addr;
        end else if (is_jal) begin
            _next_pc = _inst_addr + jal_imm;
        end else if (is_br && pred_msb) begin
            _next_pc = _inst_addr + br_imm;
        end

        _stall = !_br_rob && ((state_q == S_WAIT) || (_inst_ready_in && is_jalr));

        case (state_q)
            S_IDLE: begin
                if (_inst_ready_in && is_jalr && !_br_rob && !_clear) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (_br_rob || _clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating increment/decrement of the committed branch's counter
    always_comb begin
        ctr_d = ctr_cur;
        if (_upd_taken) begin
            if (ctr_cur != CTR_MAX) begin
                ctr_d = ctr_cur + CTR_W'(1);
            end
        end else begin
            if (ctr_cur != '0) begin
                ctr_d = ctr_cur - CTR_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Counter table: bulk reset, single-entry write per commit
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT_V;
            end
        end else if (rdy_in && _upd_valid) begin
            ctr_q[upd_idx] <= ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: two configurations driven in lockstep against a table-of-counters model.
module tb_branch_predictor;

    localparam int K_OTH  = 0;
    localparam int K_BR   = 1;
    localparam int K_JAL  = 2;
    localparam int K_JALR = 3;

    // config A: 64 entries, 2-bit counters; config B: 16 entries, 3-bit counters
    localparam int A_ENT = 64;
    localparam int A_MAX = 3;
    localparam int A_INIT = 2;
    localparam int B_ENT = 16;
    localparam int B_MAX = 7;
    localparam int B_INIT = 4;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        br_rob;
    logic [31:0] rob_pc;
    logic [31:0] rob_imm;
    logic        clr;
    logic [31:0] inst;
    logic        inst_rdy;
    logic [31:0] inst_addr;
    logic        upd_v;
    logic [31:0] upd_pc;
    logic        upd_t;
    logic        stall_a, pred_a, stall_b, pred_b;
    logic [31:0] npc_a, npc_b;

    // behavioural view of what is being presented
    int          cur_kind;
    logic [31:0] cur_imm;

    // model state
    int ctr_a [A_ENT];
    int ctr_b [B_ENT];
    bit m_wait;

    int n_vec;
    int n_err;

    branch_predictor #(.BHT_IDX_W(6), .CTR_W(2)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        ._br_rob(br_rob), ._rob_new_pc(rob_pc), ._rob_imm(rob_imm), ._clear(clr),
        ._inst_in(inst), ._inst_ready_in(inst_rdy), ._inst_addr(inst_addr),
        ._upd_valid(upd_v), ._upd_pc(upd_pc), ._upd_taken(upd_t),
        ._stall(stall_a), ._next_pc(npc_a), ._pred_taken(pred_a)
    );

    branch_predictor #(.BHT_IDX_W(4), .CTR_W(3)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        ._br_rob(br_rob), ._rob_new_pc(rob_pc), ._rob_imm(rob_imm), ._clear(clr),
        ._inst_in(inst), ._inst_ready_in(inst_rdy), ._inst_addr(inst_addr),
        ._upd_valid(upd_v), ._upd_pc(upd_pc), ._upd_taken(upd_t),
        ._stall(stall_b), ._next_pc(npc_b), ._pred_taken(pred_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V encoding of a given instruction kind and immediate
    function automatic logic [31:0] enc(int k, logic [31:0] imm, logic [31:0] rnd);
        case (k)
            K_BR:    return {imm[12], imm[10:5], rnd[24:20], rnd[19:15], rnd[14:12],
                             imm[4:1], imm[11], 7'b1100011};
            K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rnd[11:7], 7'b1101111};
            K_JALR:  return {rnd[31:7], 7'b1100111};
            default: return {rnd[31:7], 7'b0010011};
        endcase
    endfunction

    function automatic bit m_taken(int cfg, logic [31:0] pc);
        int i;
        if (cfg == 0) begin
            i = int'((pc >> 2) & 32'(A_ENT - 1));
            return ctr_a[i] >= (A_MAX + 1) / 2;
        end
        i = int'((pc >> 2) & 32'(B_ENT - 1));
        return ctr_b[i] >= (B_MAX + 1) / 2;
    endfunction

    function automatic logic [31:0] m_next_pc(int cfg);
        if (br_rob) return rob_pc + rob_imm;
        if (m_wait || !inst_rdy) return inst_addr;
        if (cur_kind == K_JAL) return inst_addr + cur_imm;
        if (cur_kind == K_BR && m_taken(cfg, inst_addr)) return inst_addr + cur_imm;
        return inst_addr + 32'd4;
    endfunction

    function automatic bit m_pred(int cfg);
        return inst_rdy && cur_kind == K_BR && m_taken(cfg, inst_addr);
    endfunction

    function automatic bit m_stall();
        if (br_rob) return 1'b0;
        return m_wait || (inst_rdy && cur_kind == K_JALR);
    endfunction

    // model state transition at a clock edge
    task automatic m_clock();
        int ia, ib;
        if (!rst_n) begin
            foreach (ctr_a[i]) ctr_a[i] = A_INIT;
            foreach (ctr_b[i]) ctr_b[i] = B_INIT;
            m_wait = 1'b0;
        end else if (rdy) begin
            if (upd_v) begin
                ia = int'((upd_pc >> 2) & 32'(A_ENT - 1));
                ib = int'((upd_pc >> 2) & 32'(B_ENT - 1));
                if (upd_t) begin
                    ctr_a[ia] = (ctr_a[ia] < A_MAX) ? ctr_a[ia] + 1 : A_MAX;
                    ctr_b[ib] = (ctr_b[ib] < B_MAX) ? ctr_b[ib] + 1 : B_MAX;
                end else begin
                    ctr_a[ia] = (ctr_a[ia] > 0) ? ctr_a[ia] - 1 : 0;
                    ctr_b[ib] = (ctr_b[ib] > 0) ? ctr_b[ib] - 1 : 0;
                end
            end
            if (m_wait) begin
                if (br_rob || clr) m_wait = 1'b0;
            end else if (inst_rdy && cur_kind == K_JALR && !br_rob && !clr) begin
                m_wait = 1'b1;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(string nm);
        chk({nm, " npc_a"},   npc_a,          m_next_pc(0));
        chk({nm, " npc_b"},   npc_b,          m_next_pc(1));
        chk({nm, " pred_a"},  32'(pred_a),    32'(m_pred(0)));
        chk({nm, " pred_b"},  32'(pred_b),    32'(m_pred(1)));
        chk({nm, " stall_a"}, 32'(stall_a),   32'(m_stall()));
        chk({nm, " stall_b"}, 32'(stall_b),   32'(m_stall()));
    endtask

    // inputs are already driven; check outputs, then clock the DUTs and the model
    task automatic step(string nm);
        #1;
        check_model(nm);
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic drive(bit rdy_v, bit rdy_inst, int k, logic [31:0] addr, logic [31:0] imm,
                         bit uv, logic [31:0] upc, bit ut,
                         bit br, logic [31:0] rpc, logic [31:0] rimm, bit c);
        rdy       = rdy_v;
        inst_rdy  = rdy_inst;
        cur_kind  = k;
        cur_imm   = imm;
        inst_addr = addr;
        inst      = enc(k, imm, $urandom);
        upd_v     = uv;
        upd_pc    = upc;
        upd_t     = ut;
        br_rob    = br;
        rob_pc    = rpc;
        rob_imm   = rimm;
        clr       = c;
    endtask

    typedef struct {
        string       name;
        bit          br;
        logic [31:0] rpc;
        logic [31:0] rimm;
        bit          ready;
        int          kind;
        logic [31:0] addr;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        bit          exp_stall;
        bit          exp_pred;
    } vec_t;

    vec_t vecs [8];

    initial begin
        n_vec = 0;
        n_err = 0;
        m_wait = 1'b0;
        foreach (ctr_a[i]) ctr_a[i] = A_INIT;
        foreach (ctr_b[i]) ctr_b[i] = B_INIT;

        vecs[0] = '{"br_reset",   1'b0, 32'h0,   32'h0,  1'b1, K_BR,   32'h100, 32'd16,       32'h110,      1'b0, 1'b1};
        vecs[1] = '{"jal_neg",    1'b0, 32'h0,   32'h0,  1'b1, K_JAL,  32'h200, 32'hFFFFFFF8, 32'h1F8,      1'b0, 1'b0};
        vecs[2] = '{"jal_wrap",   1'b0, 32'h0,   32'h0,  1'b1, K_JAL,  32'h0,   32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 1'b0};
        vecs[3] = '{"jalr",       1'b0, 32'h0,   32'h0,  1'b1, K_JALR, 32'h300, 32'h0,        32'h304,      1'b1, 1'b0};
        vecs[4] = '{"jalr_rob",   1'b1, 32'h400, 32'h20, 1'b1, K_JALR, 32'h300, 32'h0,        32'h420,      1'b0, 1'b0};
        vecs[5] = '{"not_ready",  1'b0, 32'h0,   32'h0,  1'b0, K_BR,   32'h500, 32'd8,        32'h500,      1'b0, 1'b0};
        vecs[6] = '{"other",      1'b0, 32'h0,   32'h0,  1'b1, K_OTH,  32'h600, 32'h0,        32'h604,      1'b0, 1'b0};
        vecs[7] = '{"br_min_imm", 1'b0, 32'h0,   32'h0,  1'b1, K_BR,   32'h7FC, 32'hFFFFF000, 32'hFFFFF7FC, 1'b0, 1'b1};

        // reset
        rst_n = 1'b0;
        drive(1'b1, 1'b0, K_OTH, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        m_clock();
        #1;
        rst_n = 1'b1;

        // combinational table with rdy_in low so nothing changes state
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vecs[i].ready, vecs[i].kind, vecs[i].addr, vecs[i].imm,
                  1'b1, 32'h100, 1'b0, vecs[i].br, vecs[i].rpc, vecs[i].rimm, 1'b0);
            #1;
            chk({vecs[i].name, " tbl npc_a"},   npc_a,         vecs[i].exp_pc);
            chk({vecs[i].name, " tbl npc_b"},   npc_b,         vecs[i].exp_pc);
            chk({vecs[i].name, " tbl stall_a"}, 32'(stall_a),  32'(vecs[i].exp_stall));
            chk({vecs[i].name, " tbl pred_a"},  32'(pred_a),   32'(vecs[i].exp_pred));
            chk({vecs[i].name, " tbl pred_b"},  32'(pred_b),   32'(vecs[i].exp_pred));
            step(vecs[i].name);
        end

        // training: two not-taken commits flip the prediction
        repeat (2) begin
            drive(1'b1, 1'b0, K_OTH, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            step("train_nt");
        end
        drive(1'b1, 1'b1, K_BR, 32'h100, 32'd16, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("trained_nt npc_a", npc_a, 32'h104);
        chk("trained_nt pred_a", 32'(pred_a), 32'd0);
        step("trained_nt");
        repeat (4) begin
            drive(1'b1, 1'b0, K_OTH, 32'h0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            step("train_t");
        end
        // saturated at 3: one not-taken leaves it weakly taken
        drive(1'b1, 1'b0, K_OTH, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step("sat_nt");
        drive(1'b1, 1'b1, K_BR, 32'h100, 32'd16, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("saturate pred_a", 32'(pred_a), 32'd1);
        step("saturate");

        // JALR wait and ROB resolve
        drive(1'b1, 1'b1, K_JALR, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("jalr stall_a", 32'(stall_a), 32'd1);
        step("jalr");
        repeat (3) begin
            drive(1'b1, 1'b1, K_OTH, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            chk("wait npc_a", npc_a, 32'h300);
            chk("wait stall_a", 32'(stall_a), 32'd1);
            step("wait");
        end
        drive(1'b1, 1'b1, K_OTH, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 32'h20, 1'b0);
        #1;
        chk("resolve npc_a", npc_a, 32'h420);
        chk("resolve stall_a", 32'(stall_a), 32'd0);
        step("resolve");
        drive(1'b1, 1'b1, K_OTH, 32'h304, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("post_resolve stall_a", 32'(stall_a), 32'd0);
        chk("post_resolve npc_a", npc_a, 32'h308);
        step("post_resolve");

        // same-cycle update and lookup: lookup sees old counter (2 -> 1)
        drive(1'b1, 1'b1, K_BR, 32'h100, 32'd16, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("same_cycle pred_a", 32'(pred_a), 32'd1);
        step("same_cycle");
        drive(1'b1, 1'b1, K_BR, 32'h100, 32'd16, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("next_cycle pred_a", 32'(pred_a), 32'd0);
        step("next_cycle");

        // JALR together with a redirect: no stall, stays idle
        drive(1'b1, 1'b1, K_JALR, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 32'h4, 1'b0);
        #1;
        chk("jalr_rob stall_a", 32'(stall_a), 32'd0);
        step("jalr_rob");
        drive(1'b1, 1'b1, K_OTH, 32'h804, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("jalr_rob idle stall_a", 32'(stall_a), 32'd0);
        step("jalr_rob_idle");

        // rdy_in low: taken update and JALR are ignored
        drive(1'b0, 1'b1, K_JALR, 32'h300, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step("rdy_low");
        drive(1'b1, 1'b1, K_BR, 32'h100, 32'd16, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rdy_low ctr pred_a", 32'(pred_a), 32'd0);
        chk("rdy_low fsm stall_a", 32'(stall_a), 32'd0);
        step("rdy_low_after");

        // reset while waiting
        drive(1'b1, 1'b1, K_JALR, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step("jalr_pre_rst");
        rst_n = 1'b0;
        drive(1'b1, 1'b0, K_OTH, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step("rst_in_wait");
        rst_n = 1'b1;
        drive(1'b1, 1'b1, K_BR, 32'h100, 32'd16, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("post_rst npc_a", npc_a, 32'h110);
        chk("post_rst npc_b", npc_b, 32'h110);
        chk("post_rst pred_b", 32'(pred_b), 32'd1);
        chk("post_rst stall_a", 32'(stall_a), 32'd0);
        step("post_rst");

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          k;
            logic [31:0] a, im, up;
            logic [12:0] b13;
            logic [20:0] j21;
            k = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? ($urandom & ~32'd3) : (32'($urandom_range(0, 255)) << 2);
            up = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 255)) << 2);
            b13 = 13'($urandom) & ~13'd1;
            j21 = 21'($urandom) & ~21'd1;
            im = (k == K_BR) ? {{19{b13[12]}}, b13} : (k == K_JAL) ? {{11{j21[20]}}, j21} : 32'h0;
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, k, a, im,
                  $urandom_range(0, 1) == 1, up, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, $urandom, $urandom, $urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
